// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB/I2C register-write target:
// FSM state encoding, OV5640 bus address constants and ACK/NACK levels.
package sccb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV,
    ST_DEV_ACK,
    ST_AHI,
    ST_AHI_ACK,
    ST_ALO,
    ST_ALO_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_IGNORE,
    ST_TX,
    ST_TX_ACK
  } sccb_state_t;

  localparam logic [6:0] OV5640_DEV_ADDR = 7'h3C;
  localparam logic [7:0] OV5640_WR_BYTE  = 8'h78;
  localparam logic [7:0] OV5640_RD_BYTE  = 8'h79;

  localparam logic ACK_BIT  = 1'b0;
  localparam logic NACK_BIT = 1'b1;

  // Register pointer advance; natural 16-bit wrap FFFF -> 0000.
  function automatic logic [15:0] ptr_next(input logic [15:0] ptr);
    return ptr + 16'd1;
  endfunction

endpackage

// File: rtl/sccb_line_sync.sv
// Synchroniser and bus event detector for the open-drain SCL/SDA pads.
// Both lines go through SYNC_STAGES flops and one history flop. An SCL edge
// takes priority: START/STOP are only declared while SCL is stable high.
module sccb_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic meg25,
  input  logic reset_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_s;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_edge;

  // Synchroniser chains and history flops; reset to the idle (high) bus level
  // so leaving reset does not fabricate a START.
  always_ff @(posedge meg25 or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  // Edge and bus-condition decode from the synchronised and history values.
  always_comb begin
    scl_edge  = scl_s ^ scl_d;
    scl_rise  = scl_s & ~scl_d;
    scl_fall  = ~scl_s & scl_d;
    start_det = ~scl_edge & scl_s & sda_d & ~sda_s;
    stop_det  = ~scl_edge & scl_s & ~sda_d & sda_s;
  end

endmodule

// File: rtl/sccb_target.sv
// SCCB/I2C target modelling the OV5640 register-write port: decodes START/
// STOP, matches the device address, ACKs bytes and strobes 16-bit-address /
// 8-bit-data register writes with an auto-incrementing pointer.
// Optional read path enabled by defining SCCB_TARGET_READ_EN.
//
// state       | meaning
// ------------+------------------------------------------------------
// ST_IDLE     | bus free, waiting for START
// ST_DEV      | shifting device address + R/W bit
// ST_DEV_ACK  | driving ACK for the device address
// ST_AHI      | shifting register pointer high byte
// ST_AHI_ACK  | driving ACK for pointer high byte
// ST_ALO      | shifting register pointer low byte
// ST_ALO_ACK  | driving ACK for pointer low byte
// ST_DATA     | shifting a write data byte
// ST_DATA_ACK | driving ACK for data (write strobed on entry)
// ST_IGNORE   | not addressed or read ended, wait for START/STOP
// ST_TX       | shifting a read byte out (read build only)
// ST_TX_ACK   | SDA released, sampling master ACK/NACK (read build only)
module sccb_target import sccb_pkg::*; #(
  parameter logic [6:0] DEV_ADDR    = OV5640_DEV_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        meg25,
  input  logic        reset_n,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic        wr_valid,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  input  logic [7:0]  rd_data,
  output logic [15:0] rd_addr
);

  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;
  logic sda_s;

  sccb_state_t state, state_nxt;
  logic [3:0]  bit_cnt, bit_cnt_nxt;
  logic [7:0]  shift, shift_nxt;
  logic [15:0] pointer, pointer_nxt;
  logic        sda_oe_nxt;
  logic        wr_valid_nxt;
  logic [15:0] wr_addr_nxt;
  logic [7:0]  wr_data_nxt;
  logic        busy_nxt;
  logic        rx_state;
  logic        byte_done;
  logic        addr_hit;

`ifdef SCCB_TARGET_READ_EN
  logic        rd_mode, rd_mode_nxt;
  logic [7:0]  tx_shift, tx_shift_nxt;
`endif

  sccb_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .meg25     (meg25),
    .reset_n   (reset_n),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  // State and datapath registers; async reset releases SDA immediately.
  always_ff @(posedge meg25 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      shift    <= '0;
      pointer  <= '0;
      sda_oe   <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
`ifdef SCCB_TARGET_READ_EN
      rd_mode  <= 1'b0;
      tx_shift <= '0;
`endif
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shift    <= shift_nxt;
      pointer  <= pointer_nxt;
      sda_oe   <= sda_oe_nxt;
      wr_valid <= wr_valid_nxt;
      wr_addr  <= wr_addr_nxt;
      wr_data  <= wr_data_nxt;
      busy     <= busy_nxt;
`ifdef SCCB_TARGET_READ_EN
      rd_mode  <= rd_mode_nxt;
      tx_shift <= tx_shift_nxt;
`endif
    end
  end

  // Next-state and output decode; START/STOP override everything else.
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    shift_nxt    = shift;
    pointer_nxt  = pointer;
    sda_oe_nxt   = sda_oe;
    wr_valid_nxt = 1'b0;
    wr_addr_nxt  = wr_addr;
    wr_data_nxt  = wr_data;
    busy_nxt     = busy;
`ifdef SCCB_TARGET_READ_EN
    rd_mode_nxt  = rd_mode;
    tx_shift_nxt = tx_shift;
`endif

    rx_state  = (state == ST_DEV) || (state == ST_AHI) ||
                (state == ST_ALO) || (state == ST_DATA);
    byte_done = scl_fall && (bit_cnt == 4'd8);
    addr_hit  = (shift[7:1] == DEV_ADDR);

    if (stop_det) begin
      state_nxt   = ST_IDLE;
      bit_cnt_nxt = '0;
      sda_oe_nxt  = 1'b0;
      busy_nxt    = 1'b0;
    end else if (start_det) begin
      state_nxt   = ST_DEV;
      bit_cnt_nxt = '0;
      sda_oe_nxt  = 1'b0;
    end else begin
      if (rx_state && scl_rise && (bit_cnt != 4'd8)) begin
        shift_nxt   = {shift[6:0], sda_s};
        bit_cnt_nxt = bit_cnt + 4'd1;
      end

      case (state)
        ST_DEV: begin
          if (byte_done) begin
            bit_cnt_nxt = '0;
            if (addr_hit && !shift[0]) begin
              sda_oe_nxt = 1'b1;
              busy_nxt   = 1'b1;
              state_nxt  = ST_DEV_ACK;
`ifdef SCCB_TARGET_READ_EN
              rd_mode_nxt = 1'b0;
`endif
            end
`ifdef SCCB_TARGET_READ_EN
            else if (addr_hit) begin
              sda_oe_nxt  = 1'b1;
              busy_nxt    = 1'b1;
              rd_mode_nxt = 1'b1;
              state_nxt   = ST_DEV_ACK;
            end
`endif
            else begin
              busy_nxt  = 1'b0;
              state_nxt = ST_IGNORE;
            end
          end
        end

        ST_DEV_ACK: begin
          if (scl_fall) begin
            sda_oe_nxt = 1'b0;
            state_nxt  = ST_AHI;
`ifdef SCCB_TARGET_READ_EN
            if (rd_mode) begin
              tx_shift_nxt = rd_data;
              sda_oe_nxt   = ~rd_data[7];
              bit_cnt_nxt  = 4'd1;
              state_nxt    = ST_TX;
            end
`endif
          end
        end

        ST_AHI: begin
          if (byte_done) begin
            pointer_nxt[15:8] = shift;
            sda_oe_nxt        = 1'b1;
            bit_cnt_nxt       = '0;
            state_nxt         = ST_AHI_ACK;
          end
        end

        ST_AHI_ACK: begin
          if (scl_fall) begin
            sda_oe_nxt = 1'b0;
            state_nxt  = ST_ALO;
          end
        end

        ST_ALO: begin
          if (byte_done) begin
            pointer_nxt[7:0] = shift;
            sda_oe_nxt       = 1'b1;
            bit_cnt_nxt      = '0;
            state_nxt        = ST_ALO_ACK;
          end
        end

        ST_ALO_ACK: begin
          if (scl_fall) begin
            sda_oe_nxt = 1'b0;
            state_nxt  = ST_DATA;
          end
        end

        ST_DATA: begin
          if (byte_done) begin
            sda_oe_nxt   = 1'b1;
            wr_valid_nxt = 1'b1;
            wr_addr_nxt  = pointer;
            wr_data_nxt  = shift;
            pointer_nxt  = ptr_next(pointer);
            bit_cnt_nxt  = '0;
            state_nxt    = ST_DATA_ACK;
          end
        end

        ST_DATA_ACK: begin
          if (scl_fall) begin
            sda_oe_nxt = 1'b0;
            state_nxt  = ST_DATA;
          end
        end

`ifdef SCCB_TARGET_READ_EN
        ST_TX: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_nxt  = 1'b0;
              bit_cnt_nxt = '0;
              state_nxt   = ST_TX_ACK;
            end else begin
              tx_shift_nxt = {tx_shift[6:0], 1'b0};
              sda_oe_nxt   = ~tx_shift[6];
              bit_cnt_nxt  = bit_cnt + 4'd1;
            end
          end
        end

        // Pointer advances on the ACK rise so rd_data for the next byte is
        // already valid when it is loaded on the following fall.
        ST_TX_ACK: begin
          if (scl_rise) begin
            if (sda_s == ACK_BIT) begin
              pointer_nxt = ptr_next(pointer);
            end else begin
              state_nxt = ST_IGNORE;
            end
          end else if (scl_fall) begin
            tx_shift_nxt = rd_data;
            sda_oe_nxt   = ~rd_data[7];
            bit_cnt_nxt  = 4'd1;
            state_nxt    = ST_TX;
          end
        end
`endif

        default: ;
      endcase
    end
  end

`ifdef SCCB_TARGET_READ_EN
  assign rd_addr = pointer;
`else
  logic unused_rd_data;
  assign unused_rd_data = ^rd_data;
  assign rd_addr        = '0;
`endif

endmodule

// File: tb/tb_sccb_target.sv
// Directed bench for sccb_target: bit-bangs an open-drain SCCB master and
// compares ACKs, write strobes and status outputs with hand-computed values.
`timescale 1ns/1ps
module tb_sccb_target;
  import sccb_pkg::*;

  logic        meg25   = 1'b0;
  logic        reset_n = 1'b0;
  logic        scl_m   = 1'b1;
  logic        sda_m   = 1'b1;
  logic [7:0]  rd_data = 8'h56;
  logic        scl_in;
  logic        sda_in;
  logic        sda_line;
  logic        sda_oe;
  logic        wr_valid;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic [15:0] rd_addr;

  int chk_cnt = 0;
  int err_cnt = 0;
  int q       = 2500;

  int          wr_cnt   = 0;
  int          oe_cnt   = 0;
  int          busy_cnt = 0;
  logic [15:0] wa [32];
  logic [7:0]  wd [32];

  assign sda_line = sda_m & ~sda_oe;
  assign scl_in   = scl_m;
  assign sda_in   = sda_line;

  always #20 meg25 = ~meg25;

  sccb_target dut (
    .meg25    (meg25),
    .reset_n  (reset_n),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .sda_oe   (sda_oe),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .rd_data  (rd_data),
    .rd_addr  (rd_addr)
  );

  // Log write strobes and activity away from the active clock edge.
  always @(negedge meg25) begin
    if (wr_valid) begin
      if (wr_cnt < 32) begin
        wa[wr_cnt] = wr_addr;
        wd[wr_cnt] = wr_data;
      end
      wr_cnt++;
    end
    if (sda_oe) oe_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic bus_start();
    sda_m = 1'b1; #(q);
    scl_m = 1'b1; #(q);
    sda_m = 1'b0; #(q);
    scl_m = 1'b0; #(q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #(q);
    scl_m = 1'b1; #(q);
    sda_m = 1'b1; #(q);
    repeat (10) @(negedge meg25);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sda_m = b[i]; #(q);
      scl_m = 1'b1; #(2*q);
      scl_m = 1'b0; #(q);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    sda_m = 1'b1; #(q);
    scl_m = 1'b1; #(q);
    ack = sda_line; #(q);
    scl_m = 1'b0; #(q);
  endtask

  task automatic read_byte(output logic [7:0] b);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      #(q);
      scl_m = 1'b1; #(q);
      b[i] = sda_line; #(q);
      scl_m = 1'b0; #(q);
    end
  endtask

  task automatic write_txn(input string pfx, input logic [7:0] ah, input logic [7:0] al,
                           input logic [7:0] d);
    logic ack;
    bus_start();
    send_byte(OV5640_WR_BYTE, ack); chk({pfx, "_ack_dev"}, ack, ACK_BIT);
    send_byte(ah, ack);             chk({pfx, "_ack_ahi"}, ack, ACK_BIT);
    send_byte(al, ack);             chk({pfx, "_ack_alo"}, ack, ACK_BIT);
    send_byte(d, ack);              chk({pfx, "_ack_dat"}, ack, ACK_BIT);
    chk({pfx, "_busy_before_stop"}, busy, 1'b1);
    bus_stop();
    chk({pfx, "_busy_after_stop"}, busy, 1'b0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  initial begin
    logic       ack;
    logic [7:0] rb;
    int         base;
    int         ob;
    int         bb;

    #30;
    chk("rst_sda_oe", sda_oe, 1'b0);
    chk("rst_wr_valid", wr_valid, 1'b0);
    chk("rst_wr_addr", wr_addr, 16'h0000);
    chk("rst_wr_data", wr_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd_addr", rd_addr, 16'h0000);
    #100;
    reset_n = 1'b1;
    repeat (5) @(negedge meg25);

    // 1: single write at 100 kHz
    q = 2500;
    base = wr_cnt;
    write_txn("s1", 8'h30, 8'h08, 8'h82);
    chk("s1_wr_count", wr_cnt - base, 1);
    chk("s1_wr_addr", wa[base], 16'h3008);
    chk("s1_wr_data", wd[base], 8'h82);

    // 2: wrong device address is never acknowledged
    q = 625;
    base = wr_cnt; ob = oe_cnt; bb = busy_cnt;
    bus_start();
    send_byte(8'h7A, ack); chk("s2_nack_dev", ack, NACK_BIT);
    send_byte(8'h30, ack); chk("s2_nack_ahi", ack, NACK_BIT);
    bus_stop();
    chk("s2_oe_cycles", oe_cnt - ob, 0);
    chk("s2_wr_count", wr_cnt - base, 0);
    chk("s2_busy_cycles", busy_cnt - bb, 0);

    // 3: burst across the pointer wrap
    base = wr_cnt;
    bus_start();
    send_byte(OV5640_WR_BYTE, ack); chk("s3_ack_dev", ack, ACK_BIT);
    send_byte(8'hFF, ack);          chk("s3_ack_ahi", ack, ACK_BIT);
    send_byte(8'hFF, ack);          chk("s3_ack_alo", ack, ACK_BIT);
    send_byte(8'h11, ack);          chk("s3_ack_d0", ack, ACK_BIT);
    send_byte(8'h22, ack);          chk("s3_ack_d1", ack, ACK_BIT);
    bus_stop();
    chk("s3_wr_count", wr_cnt - base, 2);
    chk("s3_wr_addr0", wa[base], 16'hFFFF);
    chk("s3_wr_data0", wd[base], 8'h11);
    chk("s3_wr_addr1", wa[base+1], 16'h0000);
    chk("s3_wr_data1", wd[base+1], 8'h22);

    // 4: STOP inside a data byte discards it
    base = wr_cnt;
    bus_start();
    send_byte(OV5640_WR_BYTE, ack); chk("s4_ack_dev", ack, ACK_BIT);
    send_byte(8'h30, ack);          chk("s4_ack_ahi", ack, ACK_BIT);
    send_byte(8'h08, ack);          chk("s4_ack_alo", ack, ACK_BIT);
    send_bits(8'hA5, 5);
    bus_stop();
    chk("s4_state_idle", dut.state, ST_IDLE);
    chk("s4_sda_oe", sda_oe, 1'b0);
    chk("s4_busy", busy, 1'b0);
    chk("s4_wr_count", wr_cnt - base, 0);
    base = wr_cnt;
    write_txn("s4b", 8'h12, 8'h34, 8'h56);
    chk("s4b_wr_count", wr_cnt - base, 1);
    chk("s4b_wr_addr", wa[base], 16'h1234);
    chk("s4b_wr_data", wd[base], 8'h56);

    // 5: reset during the device-address ACK low phase
    bus_start();
    send_bits(OV5640_WR_BYTE, 8);
    sda_m = 1'b1;
    for (int i = 0; i < 1000 && !sda_oe; i++) @(negedge meg25);
    chk("s5_ack_driven", sda_oe, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("s5_rst_sda_oe", sda_oe, 1'b0);
    chk("s5_rst_busy", busy, 1'b0);
    chk("s5_rst_wr_addr", wr_addr, 16'h0000);
    chk("s5_rst_wr_data", wr_data, 8'h00);
    chk("s5_rst_state", dut.state, ST_IDLE);
    #(q);
    reset_n = 1'b1;
    repeat (5) @(negedge meg25);
    bus_stop();
    base = wr_cnt;
    write_txn("s5b", 8'h31, 8'h00, 8'h5A);
    chk("s5b_wr_count", wr_cnt - base, 1);
    chk("s5b_wr_addr", wa[base], 16'h3100);
    chk("s5b_wr_data", wd[base], 8'h5A);

    // 6: set pointer, repeated START, read address
    bus_start();
    send_byte(OV5640_WR_BYTE, ack); chk("s6_ack_dev", ack, ACK_BIT);
    send_byte(8'h30, ack);          chk("s6_ack_ahi", ack, ACK_BIT);
    send_byte(8'h0A, ack);          chk("s6_ack_alo", ack, ACK_BIT);
    bus_start();
`ifdef SCCB_TARGET_READ_EN
    send_byte(OV5640_RD_BYTE, ack); chk("s6_ack_rd", ack, ACK_BIT);
    chk("s6_rd_addr", rd_addr, 16'h300A);
    read_byte(rb);
    chk("s6_rd_byte", rb, 8'h56);
    chk("s6_busy", busy, 1'b1);
    sda_m = 1'b1; #(q);
    scl_m = 1'b1; #(2*q);
    scl_m = 1'b0; #(q);
    chk("s6_released_after_nack", sda_oe, 1'b0);
    chk("s6_state_ignore", dut.state, ST_IGNORE);
`else
    send_byte(OV5640_RD_BYTE, ack); chk("s6_nack_rd", ack, NACK_BIT);
    chk("s6_busy", busy, 1'b0);
    chk("s6_rd_addr", rd_addr, 16'h0000);
    rb = 8'h00;
    chk("s6_rd_byte_unused", rb, 8'h00);
`endif
    bus_stop();
    chk("s6_busy_after_stop", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
